// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Step counter must be able to hold the value BITS itself.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

  localparam logic [31:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS:0]   rem_i,
  input  logic            bit_i,
  input  logic [BITS-1:0] divisor_i,
  output logic [BITS:0]   rem_o,
  output logic            q_o
);

  logic [BITS:0]   shifted;
  logic [BITS+1:0] diff;
  logic            borrow;
  // R[BITS] is always 0 entering a step, since R < divisor after every step.
  logic            unused_rem_msb;

  always_comb begin
    unused_rem_msb = rem_i[BITS];
    shifted        = {rem_i[BITS-1:0], bit_i};
    diff           = {1'b0, shifted} - {2'b00, divisor_i};
    borrow         = diff[BITS+1];
    rem_o          = borrow ? shifted : diff[BITS:0];
    q_o            = ~borrow;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [BITS-1:0] i_dividend,
  input  logic [BITS-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_quotient,
  output logic [BITS-1:0] o_remainder,
  output logic            o_div_by_zero
);

  localparam int unsigned CW = cnt_width(BITS);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] dvd_q, dvd_d;
  logic [BITS-1:0] dvs_q, dvs_d;
  logic [BITS:0]   rem_q, rem_d;
  logic [BITS-1:0] quo_q, quo_d;
  logic [BITS-1:0] quotient_q, quotient_d;
  logic [BITS-1:0] remainder_q, remainder_d;
  logic            div0_q, div0_d;

  logic [BITS:0]   step_rem;
  logic            step_q;

  div_step #(.BITS(BITS)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[BITS-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          if (i_divisor == '0) begin
            state_d     = DONE;
            quotient_d  = DIV0_QUOTIENT[BITS-1:0];
            remainder_d = i_dividend;
            div0_d      = 1'b1;
          end else begin
            state_d = RUN;
            dvd_d   = i_dividend;
            dvs_d   = i_divisor;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(BITS);
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[BITS-2:0], 1'b0};
        quo_d = {quo_q[BITS-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        // Last step: publish this step's result directly rather than a cycle later.
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = {quo_q[BITS-2:0], step_q};
          remainder_d = step_rem[BITS-1:0];
          div0_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
    end
  end

  always_comb begin
    o_busy        = (state_q == RUN);
    o_done        = (state_q == DONE);
    o_quotient    = quotient_q;
    o_remainder   = remainder_q;
    o_div_by_zero = div0_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned BITS = 8;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_start = 1'b0;
  logic [BITS-1:0] i_dividend = '0;
  logic [BITS-1:0] i_divisor = '0;
  logic            o_busy;
  logic            o_done;
  logic [BITS-1:0] o_quotient;
  logic [BITS-1:0] o_remainder;
  logic            o_div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [BITS-1:0] exp_q = '0;
  logic [BITS-1:0] exp_r = '0;
  logic            exp_dz = 1'b0;

  seq_divider #(.BITS(BITS)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end, observed running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [BITS-1:0] ref_q(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [BITS-1:0] ref_r(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    if (b == '0) return a;
    return a % b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_quotient"}, 32'(o_quotient), 32'(exp_q));
    chk({tag, "_remainder"}, 32'(o_remainder), 32'(exp_r));
    chk({tag, "_dz"}, 32'(o_div_by_zero), 32'(exp_dz));
  endtask

  // Called in the cycle right after the accepting edge; returns in the done cycle.
  task automatic watch(input string tag, input int lat, input logic [BITS-1:0] a,
                       input logic [BITS-1:0] b);
    for (int j = 1; j <= lat; j++) begin
      if (j > 1) tick();
      chk({tag, "_busy"}, 32'(o_busy), 32'(j < lat));
      chk({tag, "_done"}, 32'(o_done), 32'(j == lat));
      if (j < lat) begin
        chk({tag, "_hold_q"}, 32'(o_quotient), 32'(exp_q));
        chk({tag, "_hold_r"}, 32'(o_remainder), 32'(exp_r));
      end
    end
    exp_q  = ref_q(a, b);
    exp_r  = ref_r(a, b);
    exp_dz = (b == '0);
    chk_results(tag);
  endtask

  task automatic job(input string tag, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    i_dividend = BITS'($urandom);
    i_divisor  = BITS'($urandom);
    watch(tag, (b == '0) ? 1 : int'(BITS) + 1, a, b);
    tick();
    chk({tag, "_idle_done"}, 32'(o_done), 32'(0));
    chk({tag, "_idle_busy"}, 32'(o_busy), 32'(0));
  endtask

  initial begin
    logic [BITS-1:0] ra, rb;

    #1;
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk_results("rst");
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    job("d100_7", 8'd100, 8'd7);
    job("d255_1", 8'd255, 8'd1);
    job("d5_9", 8'd5, 8'd9);
    job("d200_200", 8'd200, 8'd200);
    job("d77_0", 8'd77, 8'd0);
    job("d9_3", 8'd9, 8'd3);
    job("d0_5", 8'd0, 8'd5);
    job("d255_255", 8'd255, 8'd255);

    // i_start pulsed with other operands while running must be ignored
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 1; j <= int'(BITS) + 1; j++) begin
      if (j > 1) tick();
      chk("ign_busy", 32'(o_busy), 32'(j <= int'(BITS)));
      chk("ign_done", 32'(o_done), 32'(j == int'(BITS) + 1));
      if (j == 3) begin
        i_start    = 1'b1;
        i_dividend = 8'd50;
        i_divisor  = 8'd5;
      end
      if (j == 4) i_start = 1'b0;
    end
    exp_q  = 8'd14;
    exp_r  = 8'd2;
    exp_dz = 1'b0;
    chk_results("ign");
    tick();
    chk("ign_single_pulse", 32'(o_done), 32'(0));

    // reset mid-run aborts the job
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 1; j < 4; j++) tick();
    i_rst_n = 1'b0;
    #1;
    exp_q  = '0;
    exp_r  = '0;
    exp_dz = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'(0));
    chk("abort_done", 32'(o_done), 32'(0));
    chk_results("abort");
    tick();
    tick();
    i_rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("abort_no_done", 32'(o_done), 32'(0));
      chk("abort_no_busy", 32'(o_busy), 32'(0));
    end
    job("d30_4", 8'd30, 8'd4);

    // back-to-back: start held high, new operands applied in the DONE cycle
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    tick();
    watch("b2b_first", int'(BITS) + 1, 8'd100, 8'd7);
    i_dividend = 8'd63;
    i_divisor  = 8'd8;
    tick();
    i_start = 1'b0;
    watch("b2b_second", int'(BITS) + 1, 8'd63, 8'd8);
    tick();
    chk("b2b_idle", 32'(o_done), 32'(0));

    // divide-by-zero back-to-back into a normal job
    i_dividend = 8'd77;
    i_divisor  = 8'd0;
    i_start    = 1'b1;
    tick();
    watch("b2b_dz", 1, 8'd77, 8'd0);
    i_dividend = 8'd9;
    i_divisor  = 8'd3;
    tick();
    i_start = 1'b0;
    watch("b2b_after_dz", int'(BITS) + 1, 8'd9, 8'd3);
    tick();

    for (int n = 0; n < 30; n++) begin
      ra = BITS'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) rb = '0;
      else if ($urandom_range(0, 1) == 0) rb = BITS'($urandom_range(1, 15));
      else rb = BITS'($urandom_range(1, 255));
      job("rand", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative unsigned restoring divider. It is the sequential consumer of the subtract/compare datapath and computes quotient and remainder one bit per clock. It sits beside the combinational ALU, which cannot divide in a single cycle. Control is a start/busy/done handshake toward the control unit.

Parameters:
BITS, 8, operand, quotient and remainder width (legal range 2..32)

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  request a division; sampled only when accepting (IDLE or DONE)
i_dividend  input  BITS  unsigned dividend, captured on the accepting edge
i_divisor  input  BITS  unsigned divisor, captured on the accepting edge
o_busy  output  1  high while in RUN
o_done  output  1  one-cycle pulse; results valid from this cycle onward
o_quotient  output  BITS  registered quotient
o_remainder  output  BITS  registered remainder
o_div_by_zero  output  1  registered flag; set when the captured divisor was 0

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE; o_busy, o_done, o_div_by_zero = 0; o_quotient, o_remainder = 0; all internal registers 0.
- Reset mid-operation aborts immediately; no o_done is produced for the aborted job.
- States:
  - IDLE: o_busy=0, o_done=0.
  - RUN: o_busy=1.
  - DONE: o_done=1 for exactly this one cycle.
- Transitions:
  - IDLE or DONE, i_start=1, divisor≠0 -> RUN. Capture operands, clear partial remainder R (BITS+1 bits), load step counter = BITS.
  - IDLE or DONE, i_start=1, divisor=0 -> DONE next edge. o_quotient = all ones, o_remainder = dividend, o_div_by_zero = 1.
  - RUN -> DONE on the edge where the counter reaches 0, after exactly BITS steps. Register o_quotient and o_remainder = R[BITS-1:0]; o_div_by_zero = 0.
  - DONE, i_start=0 -> IDLE.
- Start-accepting edge k (non-zero divisor): o_busy high in cycles k+1..k+BITS. o_done high in cycle k+BITS+1, i.e. latency BITS+1 edges.
- Divide-by-zero latency: o_done one edge after acceptance; o_busy never asserts.
- Restoring step (one per RUN cycle):
  - R' = {R[BITS-1:0], dividend MSB}, then shift the dividend left.
  - trial = R' − {0, divisor}, computed BITS+1 bits wide.
  - No borrow -> R = trial, shift 1 into the quotient. Borrow -> R = R', shift 0 into the quotient.
- i_start during RUN is ignored; operands are not recaptured and no error is flagged.
- i_start in the DONE cycle is accepted (back-to-back). o_done still pulses that cycle; RUN starts next edge.
- o_quotient, o_remainder and o_div_by_zero hold their last values until the next job's DONE edge. They do not change during RUN.
- Operand changes after the accepting edge have no effect.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, RUN, DONE}
  - function for counter width $clog2(BITS+1)
  - constant for the all-ones quotient on divide-by-zero
- Sub-module div_step: purely combinational, BITS parameter.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Built on the existing subtract block, using its borrow/carry output for the decision.
- Top seq_divider holds the FSM, counter and registers.

Test Plan:
- BITS=8, dividend=100, divisor=7, start at edge k -> o_busy high cycles k+1..k+8; o_done only in cycle k+9; quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 200/200 -> quotient=1, remainder=0.
- 77/0 -> o_done one cycle after acceptance, o_busy never high; quotient=0xFF, remainder=77, div_by_zero=1. A following 9/3 clears the flag: quotient=3, remainder=0.
- Start 100/7, then pulse i_start with 50/5 in RUN cycle 3 -> ignored; result 14/2; o_done single pulse at the original time.
- Start 100/7, deassert i_rst_n in RUN cycle 4 -> all outputs 0 immediately; no o_done after release; a new 30/4 gives 7/2.
- Back-to-back: i_start held high with 100/7, then 63/8 applied in the DONE cycle -> first o_done shows 14/2; second o_done exactly 9 cycles later shows 7/7.
